// File: rtl/seq_throughout_checker.sv
// seq_throughout_checker
//   Multi-channel "rise(trig) |-> hold throughout (evt[->GOTO_N]) within
//   TIMEOUT cycles" monitor. Each channel runs a non-overlapping attempt and
//   reports registered pass/fail pulses with a fail cause. Saturating
//   aggregate counters and a sticky fail flag summarize all channels.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            global enable for new attempts (open attempts keep running)
//   clr           clears counters and sticky_fail only
//   trig/hold/evt per-channel antecedent / throughout signal / event
//   busy          attempt open per channel
//   pass/fail     one-cycle result pulses; fail_cause 2 bits per channel
//                 (01 hold dropped, 10 timeout)
//   pass_cnt/fail_cnt/ign_cnt  saturating totals; sticky_fail any-fail flag

// Per-channel attempt engine.
module seq_throughout_ch #(
  parameter int GOTO_N  = 1,
  parameter int TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rise,
  input  logic       en,
  input  logic       hold,
  input  logic       evt,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [1:0] cause,
  output logic       pass_d,   // next-cycle pass, feeds the aggregate counters
  output logic       fail_d
);
  localparam int KW = (GOTO_N < 2) ? 1 : $clog2(GOTO_N + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(GOTO_N - 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, ARMED} state_t;
  state_t        state;
  logic [KW-1:0] k, k_cur;
  logic [TW-1:0] t, t_cur;
  logic          eval, hit, tmo;
  logic [1:0]    cause_d;

  // An IDLE cycle with an enabled rise is cycle 0 of the attempt, so it is
  // evaluated with zeroed event count and window index.
  always_comb begin
    eval    = (state == ARMED) | (rise & en);
    k_cur   = (state == ARMED) ? k : '0;
    t_cur   = (state == ARMED) ? t : '0;
    hit     = evt & (k_cur == K_LAST);
    tmo     = (TIMEOUT != 0) && (t_cur == T_LAST);
    pass_d  = eval & hold & hit;
    fail_d  = eval & (~hold | (~hit & tmo));
    cause_d = 2'b00;
    if (fail_d) cause_d = hold ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      t     <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
      cause <= 2'b00;
    end else begin
      pass  <= pass_d;
      fail  <= fail_d;
      cause <= cause_d;
      if (eval) begin
        if (pass_d | fail_d) begin
          state <= IDLE;
        end else begin
          state <= ARMED;
          k     <= k_cur + KW'(evt);
          t     <= t_cur + TW'(1);
        end
      end
    end
  end

  assign busy = (state == ARMED);
endmodule

module seq_throughout_checker #(
  parameter int NUM_CH  = 4,
  parameter int GOTO_N  = 1,
  parameter int TIMEOUT = 20,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NUM_CH-1:0]     trig,
  input  logic [NUM_CH-1:0]     hold,
  input  logic [NUM_CH-1:0]     evt,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     pass,
  output logic [NUM_CH-1:0]     fail,
  output logic [2*NUM_CH-1:0]   fail_cause,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      ign_cnt,
  output logic                  sticky_fail
);
  localparam int SW = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0]      trig_q, rise, ign, pass_d, fail_d;
  logic [NUM_CH-1:0][1:0] cause_a;

  assign rise       = trig & ~trig_q;
  // A rise on a busy channel (including its closing cycle) is dropped.
  assign ign        = rise & busy;
  assign fail_cause = cause_a;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    seq_throughout_ch #(.GOTO_N(GOTO_N), .TIMEOUT(TIMEOUT)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .rise   (rise[c]),
      .en     (en),
      .hold   (hold[c]),
      .evt    (evt[c]),
      .busy   (busy[c]),
      .pass   (pass[c]),
      .fail   (fail[c]),
      .cause  (cause_a[c]),
      .pass_d (pass_d[c]),
      .fail_d (fail_d[c])
    );
  end

  // Add the popcount of v to a, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [NUM_CH-1:0] v);
    logic [SW-1:0] s;
    s = SW'(a);
    for (int i = 0; i < NUM_CH; i++) s = s + SW'(v[i]);
    return (s > SW'(CMAX)) ? CMAX : CNT_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q      <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      ign_cnt     <= '0;
      sticky_fail <= 1'b0;
    end else begin
      trig_q <= trig;
      if (clr) begin
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        ign_cnt     <= '0;
        sticky_fail <= 1'b0;
      end else begin
        pass_cnt <= sat_add(pass_cnt, pass_d);
        fail_cnt <= sat_add(fail_cnt, fail_d);
        ign_cnt  <= sat_add(ign_cnt, ign);
        if (|fail_d) sticky_fail <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_throughout_checker.sv
module tb_seq_throughout_checker;
  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [3:0] trig, hold, evt;
  logic [3:0] busy0, pass0, fail0, busy1, pass1, fail1;
  logic [7:0] cause0, cause1, pc0, fc0, ic0;
  logic [1:0] pc1, fc1, ic1;
  logic       sf0, sf1;

  always #5 clk = ~clk;

  // u0: defaults. u1: GOTO_N=3, narrow saturating counters. Same stimulus.
  seq_throughout_checker #(.NUM_CH(4), .GOTO_N(1), .TIMEOUT(20), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .hold(hold), .evt(evt),
    .busy(busy0), .pass(pass0), .fail(fail0), .fail_cause(cause0),
    .pass_cnt(pc0), .fail_cnt(fc0), .ign_cnt(ic0), .sticky_fail(sf0));
  seq_throughout_checker #(.NUM_CH(4), .GOTO_N(3), .TIMEOUT(20), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .hold(hold), .evt(evt),
    .busy(busy1), .pass(pass1), .fail(fail1), .fail_cause(cause1),
    .pass_cnt(pc1), .fail_cnt(fc1), .ign_cnt(ic1), .sticky_fail(sf1));

  int ntest = 0, nfail = 0;

  // Reference model: per attempt, how many cycles it has been open and how
  // many events it has seen.
  int         G[2]    = '{1, 3};
  int         TO[2]   = '{20, 20};
  int         MAXC[2] = '{255, 3};
  bit         open_m[2][4];
  int         age_m[2][4], nev_m[2][4];
  int         pc_m[2], fc_m[2], ic_m[2];
  bit         sf_m[2];
  logic [3:0] tprev = '0;
  logic [3:0] ep[2], ef[2];
  logic [7:0] ec[2];

  task automatic chk(input string tag, input int act, input int exp);
    ntest++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  function automatic int addsat(input int a, input int b, input int m);
    return (a + b > m) ? m : a + b;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      ep[d] = '0; ef[d] = '0; ec[d] = '0;
      if (rst) begin
        for (int c = 0; c < 4; c++) begin open_m[d][c] = 0; age_m[d][c] = 0; nev_m[d][c] = 0; end
        pc_m[d] = 0; fc_m[d] = 0; ic_m[d] = 0; sf_m[d] = 0;
      end else begin
        int nign = 0;
        for (int c = 0; c < 4; c++) begin
          bit r;
          r = trig[c] && !tprev[c];
          if (open_m[d][c] && r) nign++;
          if (open_m[d][c] || (r && en)) begin
            if (!open_m[d][c]) begin age_m[d][c] = 0; nev_m[d][c] = 0; end
            if (!hold[c]) begin ef[d][c] = 1; ec[d][2*c +: 2] = 2'b01; end
            else if (evt[c] && nev_m[d][c] + 1 == G[d]) ep[d][c] = 1;
            else if (TO[d] != 0 && age_m[d][c] == TO[d] - 1) begin
              ef[d][c] = 1; ec[d][2*c +: 2] = 2'b10;
            end else begin
              open_m[d][c] = 1;
              nev_m[d][c] += int'(evt[c]);
              age_m[d][c] += 1;
            end
            if (ep[d][c] || ef[d][c]) open_m[d][c] = 0;
          end
        end
        if (clr) begin
          pc_m[d] = 0; fc_m[d] = 0; ic_m[d] = 0; sf_m[d] = 0;
        end else begin
          pc_m[d] = addsat(pc_m[d], $countones(ep[d]), MAXC[d]);
          fc_m[d] = addsat(fc_m[d], $countones(ef[d]), MAXC[d]);
          ic_m[d] = addsat(ic_m[d], nign, MAXC[d]);
          if (ef[d] != 0) sf_m[d] = 1;
        end
      end
    end
    tprev = rst ? 4'b0 : trig;
  endtask

  task automatic check_all();
    chk("u0.busy", int'(busy0), {28'b0, open_m[0][3], open_m[0][2], open_m[0][1], open_m[0][0]});
    chk("u1.busy", int'(busy1), {28'b0, open_m[1][3], open_m[1][2], open_m[1][1], open_m[1][0]});
    chk("u0.pass", int'(pass0), int'(ep[0]));
    chk("u1.pass", int'(pass1), int'(ep[1]));
    chk("u0.fail", int'(fail0), int'(ef[0]));
    chk("u1.fail", int'(fail1), int'(ef[1]));
    chk("u0.cause", int'(cause0), int'(ec[0]));
    chk("u1.cause", int'(cause1), int'(ec[1]));
    chk("u0.pass_cnt", int'(pc0), pc_m[0]);
    chk("u1.pass_cnt", int'(pc1), pc_m[1]);
    chk("u0.fail_cnt", int'(fc0), fc_m[0]);
    chk("u1.fail_cnt", int'(fc1), fc_m[1]);
    chk("u0.ign_cnt", int'(ic0), ic_m[0]);
    chk("u1.ign_cnt", int'(ic1), ic_m[1]);
    chk("u0.sticky", int'(sf0), int'(sf_m[0]));
    chk("u1.sticky", int'(sf1), int'(sf_m[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; trig = '0; evt = '0; hold = '1; en = 1; clr = 0;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; en = 1; clr = 0; trig = '0; hold = '1; evt = '0;
    @(negedge clk);
    do_reset();
    chk("reset.busy", int'(busy0), 0);
    chk("reset.pass_cnt", int'(pc0), 0);
    chk("reset.sticky", int'(sf0), 0);

    // single event at cycle 8 -> pass at cycle 9
    trig = 4'b0001;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      evt = (cyc == 8) ? 4'b0001 : 4'b0000;
      tick();
    end
    evt = '0;
    chk("A.pass", int'(pass0), 1);
    chk("A.pass_cnt", int'(pc0), 1);
    chk("A.sticky", int'(sf0), 0);

    // no event -> timeout at cycle 20, then clr
    do_reset();
    trig = 4'b0001;
    for (int cyc = 0; cyc < 20; cyc++) tick();
    chk("B.fail", int'(fail0), 1);
    chk("B.cause", int'(cause0), 2);
    chk("B.fail_cnt", int'(fc0), 1);
    chk("B.sticky", int'(sf0), 1);
    clr = 1; tick(); clr = 0;
    chk("B.clr_cnt", int'(fc0), 0);
    chk("B.clr_sticky", int'(sf0), 0);

    // hold drop beats a same-cycle event
    do_reset();
    trig = 4'b0010;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      hold = (cyc == 3) ? 4'b1101 : 4'b1111;
      evt  = (cyc == 3) ? 4'b0010 : 4'b0000;
      tick();
    end
    hold = '1; evt = '0;
    chk("C.fail", int'(fail0), 2);
    chk("C.cause", int'(cause0), 8'h04);

    // GOTO_N=3: events at 0,5,9, ignored re-rise at 4
    do_reset();
    for (int cyc = 0; cyc <= 9; cyc++) begin
      trig = (cyc == 2 || cyc == 3) ? 4'b0000 : 4'b0001;
      evt  = (cyc == 0 || cyc == 5 || cyc == 9) ? 4'b0001 : 4'b0000;
      tick();
    end
    evt = '0;
    chk("D.pass", int'(pass1), 1);
    chk("D.ign_cnt", int'(ic1), 1);
    tick();
    chk("D.no_second", int'(pass1), 0);

    // all channels pass together; u1 saturates at 3
    do_reset();
    trig = 4'b1111; evt = 4'b1111;
    tick();
    chk("E.pass_cnt4", int'(pc0), 4);
    tick(); tick();
    chk("E.pass1", int'(pass1), 15);
    chk("E.sat", int'(pc1), 3);
    evt = '0;

    // reset mid-attempt; trig high at release restarts
    do_reset();
    trig = 4'b0001;
    for (int cyc = 0; cyc < 5; cyc++) tick();
    rst = 1; tick();
    chk("F.busy_rst", int'(busy0), 0);
    tick(); rst = 0; tick();
    chk("F.restart", int'(busy0), 1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) trig[c] = ~trig[c];
        hold[c] = ($urandom_range(0, 24) != 0);
        evt[c]  = ($urandom_range(0, 4) == 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/seq_throughout_checker.md
# seq_throughout_checker

Synthesizable multi-channel sequence checker: the hardware form of "on rising trigger, hold must stay high throughout until the event has occurred N times, within a timeout window." Each channel runs an independent attempt state machine and reports pass/fail pulses with a fail cause. Aggregate saturating counters and a sticky failure flag feed the simulation scoreboard and on-chip debug status. It sits beside the DUT in simulation benches and can be synthesized into the design as a protocol monitor.

## Interface
- NUM_CH, 4, number of independent channels
- GOTO_N, 1, event occurrences required per attempt (≥1)
- TIMEOUT, 20, attempt window length in cycles; 0 disables the timeout
- CNT_W, 8, width of aggregate counters
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low blocks new attempts, in-flight attempts continue
- clr  in  1  synchronous clear of counters and sticky flag only
- trig  in  NUM_CH  per-channel antecedent; a rise starts an attempt
- hold  in  NUM_CH  per-channel signal that must stay 1 throughout the attempt
- evt  in  NUM_CH  per-channel event; counted while an attempt is open
- busy  out  NUM_CH  attempt open (registered state)
- pass  out  NUM_CH  one-cycle pulse, attempt succeeded
- fail  out  NUM_CH  one-cycle pulse, attempt failed
- fail_cause  out  2*NUM_CH  channel c at [2c+1:2c]: 01 hold dropped, 10 timeout; valid with fail, 00 otherwise
- pass_cnt  out  CNT_W  total passes, saturating
- fail_cnt  out  CNT_W  total fails, saturating
- ign_cnt  out  CNT_W  trigger rises ignored because the channel was busy, saturating
- sticky_fail  out  1  set by any fail, cleared only by rst or clr

## Operation
- Rise detect: trig_q registers trig, reset value 0; rise[c] = trig[c] & ~trig_q[c]. Trig high out of reset is a rise.
- States per channel: IDLE, ARMED. The evaluated cycle is either an ARMED cycle, or the IDLE cycle with rise & en (cycle 0 of the attempt).
- In an evaluated cycle, with k = events counted before this cycle and t = window index (0 on the rise cycle):
  - hold==0 → fail, cause 01, go IDLE. Hold is checked on cycle 0 too.
  - else if evt and k+1 == GOTO_N → pass, go IDLE. An event on cycle 0 counts.
  - else if TIMEOUT≠0 and t == TIMEOUT-1 → fail, cause 10, go IDLE.
  - else stay or enter ARMED; k += evt, t += 1.
- Priority within a cycle: hold drop > pass > timeout.
- Rise while ARMED, or in the cycle an attempt closes: ignored, no new attempt (non-overlapping), ign_cnt += 1 per channel per rise.
- An attempt closed in cycle n may restart only on a new rise at cycle ≥ n+1.
- Aggregates: pass_cnt and fail_cnt add the popcount of same-cycle results across channels, saturating at 2^CNT_W-1. clr wins over increments in the same cycle.
- rst mid-attempt: all channels return to IDLE, no pass/fail emitted, counters and sticky flag zeroed.
- Event counter width is clog2(GOTO_N+1); window timer width is clog2(TIMEOUT+1), min 1.

## Timing
- pass, fail and fail_cause are registered: asserted the cycle after the deciding cycle, for exactly one cycle.
- busy goes 1 the cycle after the rise cycle unless the attempt closed on cycle 0; busy drops in the same cycle pass/fail is asserted.
- Counters and sticky_fail update the same cycle pass/fail is visible.
- Reset values: busy, pass, fail, fail_cause, all counters, sticky_fail and trig_q are 0.
- Latency from rise to result: GOTO_N=1 with evt on the rise cycle gives the result 1 cycle later. A timeout result appears TIMEOUT cycles after the rise cycle.

## Test plan
- Defaults, ch0: trig rises at cycle 0, hold held 1, single evt pulse at cycle 8 → pass[0] at cycle 9, pass_cnt=1, sticky_fail=0.
- Ch0: trig rises at cycle 0, hold 1, no evt → fail[0] at cycle 20, cause 10, fail_cnt=1, sticky_fail=1. Then clr → counters and sticky_fail 0.
- Ch1: trig rises at cycle 0, hold drops at cycle 3 while evt arrives at cycle 3 → fail cause 01 at cycle 4 (hold priority).
- GOTO_N=3: evt at cycles 0, 5 and 9, hold 1 → pass at cycle 10. A second rise at cycle 4 → ign_cnt=1, no second result.
- All 4 channels pass in the same cycle → pass_cnt += 4. With CNT_W=2 the counter stops at 3.
- rst asserted at cycle 5 of an open attempt → busy 0 next cycle, no pass/fail ever emitted. A trig already high at rst release starts a new attempt.
